// File: rtl/imem_loader_pkg.sv
// Shared widths and load-FSM state encoding for the instruction memory loader.
// Widths match the fetch read path so loader and core agree on word and address size.
package imem_loader_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int ADDR_WIDTH  = 32;
  localparam int BYTE_WIDTH  = 8;
  localparam int WORD_BYTES  = INSTR_WIDTH / BYTE_WIDTH;

  typedef enum logic [2:0] {
    LD_IDLE = 3'd0,
    LD_HDR0 = 3'd1,
    LD_HDR1 = 3'd2,
    LD_DATA = 3'd3,
    LD_CSUM = 3'd4,
    LD_DONE = 3'd5,
    LD_ERR  = 3'd6
  } ld_state_t;

  typedef logic [BYTE_WIDTH-1:0]  img_byte_t;
  typedef logic [INSTR_WIDTH-1:0] instr_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: byte-serial image -> big-endian words into imem, XOR checksum, core hold.
// Write strobe 1 cycle after the 4th byte of a word; input pauses on in_valid gaps, never back-pressures memory.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter addr_t BASE_ADDR = '0,
  parameter int    MAX_WORDS = 256,
  parameter int    CNT_WIDTH = 16
) (
  input  logic                   clk_87,
  input  logic                   rst_n_87,
  input  logic                   start_87,
  input  logic [BYTE_WIDTH-1:0]  in_data_87,
  input  logic                   in_valid_87,
  output logic                   in_ready_87,
  output logic                   wr_en_87,
  output logic [ADDR_WIDTH-1:0]  wr_addr_87,
  output logic [INSTR_WIDTH-1:0] wr_data_87,
  output logic                   core_hold_87,
  output logic                   done_87,
  output logic                   err_87,
  output logic [CNT_WIDTH-1:0]   words_loaded_87
);

  ld_state_t                   state;
  img_byte_t                   csum;
  img_byte_t                   cnt_hi;
  logic [CNT_WIDTH-1:0]        n_words;
  logic [1:0]                  lane;
  logic [INSTR_WIDTH-9:0]      shift;

  logic                        accept;
  logic [CNT_WIDTH-1:0]        n_next;
  logic [CNT_WIDTH-1:0]        words_next;
  logic                        n_too_big;

  always_comb begin
    accept     = in_valid_87 & in_ready_87;
    n_next     = CNT_WIDTH'({cnt_hi, in_data_87});
    words_next = words_loaded_87 + CNT_WIDTH'(1);
    n_too_big  = 32'(n_next) > MAX_WORDS;
  end

  always_ff @(posedge clk_87 or negedge rst_n_87) begin
    if (!rst_n_87) begin
      state           <= LD_IDLE;
      in_ready_87     <= 1'b0;
      wr_en_87        <= 1'b0;
      wr_addr_87      <= BASE_ADDR;
      wr_data_87      <= '0;
      core_hold_87    <= 1'b1;
      done_87         <= 1'b0;
      err_87          <= 1'b0;
      words_loaded_87 <= '0;
      csum            <= '0;
      cnt_hi          <= '0;
      n_words         <= '0;
      lane            <= '0;
      shift           <= '0;
    end else begin
      wr_en_87 <= 1'b0;
      // Address advances as the strobe retires, so it is stable while wr_en is high.
      if (wr_en_87) wr_addr_87 <= wr_addr_87 + ADDR_WIDTH'(WORD_BYTES);

      case (state)
        LD_IDLE, LD_DONE, LD_ERR: begin
          if (start_87) begin
            state           <= LD_HDR0;
            in_ready_87     <= 1'b1;
            core_hold_87    <= 1'b1;
            done_87         <= 1'b0;
            err_87          <= 1'b0;
            words_loaded_87 <= '0;
            csum            <= '0;
            wr_addr_87      <= BASE_ADDR;
            lane            <= '0;
          end
        end

        LD_HDR0: begin
          if (accept) begin
            cnt_hi <= in_data_87;
            csum   <= csum ^ in_data_87;
            state  <= LD_HDR1;
          end
        end

        LD_HDR1: begin
          if (accept) begin
            csum    <= csum ^ in_data_87;
            n_words <= n_next;
            lane    <= '0;
            if (n_too_big) begin
              state       <= LD_ERR;
              in_ready_87 <= 1'b0;
              err_87      <= 1'b1;
            end else if (n_next == '0) begin
              state <= LD_CSUM;
            end else begin
              state <= LD_DATA;
            end
          end
        end

        LD_DATA: begin
          if (accept) begin
            csum  <= csum ^ in_data_87;
            shift <= {shift[INSTR_WIDTH-17:0], in_data_87};
            if (lane == 2'd3) begin
              wr_en_87        <= 1'b1;
              wr_data_87      <= {shift, in_data_87};
              words_loaded_87 <= words_next;
              lane            <= '0;
              if (words_next == n_words) state <= LD_CSUM;
            end else begin
              lane <= lane + 2'd1;
            end
          end
        end

        LD_CSUM: begin
          if (accept) begin
            in_ready_87 <= 1'b0;
            if (in_data_87 == csum) begin
              state        <= LD_DONE;
              done_87      <= 1'b1;
              core_hold_87 <= 1'b0;
            end else begin
              state  <= LD_ERR;
              err_87 <= 1'b1;
            end
          end
        end

        default: begin
          state       <= LD_IDLE;
          in_ready_87 <= 1'b0;
        end
      endcase
    end
  end

endmodule
